or_gate_sweep_checker: RTL and testbench

- Synthesizable self-checking harness for the 10-input OR gate stage; sits on both sides of the gate under test.
- Upstream: drives every input vector 0..2^WIDTH-1 into the gate, one per clock.
- Downstream: consumes the gate output, compares it against the reduction-OR of the applied vector, and reports pass/fail, error count and the first failing vector.
- Intended for on-board checking with results on LEDs/switch readback, replacing file-based simulation checking.

---
 rtl/or_gate_sweep_checker.sv | 193 +++++++++++++++++++
 tb/tb_or_gate_sweep_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/or_gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// or_gate_sweep_checker
//
// Self-checking harness that wraps a WIDTH-input OR gate under test. It drives
// every input vector 0 .. 2^WIDTH-1 onto dut_in, one per clock. It compares
// each gate response against the reduction-OR of the applied vector once
// DUT_LATENCY cycles have elapsed. It then reports the pass/fail result, a
// saturating mismatch count and the first failing vector. These results are
// meant for LEDs or switch readback on a board.
//
// Ports
//   clk            : system clock, rising edge
//   rst            : asynchronous, active-high reset
//   start          : sweep request, level sampled; accepted in IDLE or DONE
//   dut_in         : vector applied to the gate under test
//   dut_out        : gate response
//   busy           : sweep or drain in progress
//   done           : results valid, held until the next accepted start
//   pass           : sweep finished with zero mismatches (meaningful with done)
//   err_count      : number of mismatches, saturating at all-ones
//   fail_valid     : at least one mismatch has been captured
//   first_fail_vec : vector of the first mismatch
// -----------------------------------------------------------------------------
module or_gate_sweep_checker #(
  parameter int WIDTH       = 10,
  parameter int DUT_LATENCY = 0,   // legal range 0..7
  parameter int CNT_W       = 11   // must be at least WIDTH+1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] first_fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] LAST_VEC = '1;

  state_t state_q, state_d;

  // High while dut_in carries a vector that has not yet entered the compare
  // pipeline. It drops after the held final vector has been sampled once, so
  // the repeated all-ones vector in DRAIN is not compared again.
  logic drive_vld;

  // Compare tap: the record of the vector whose gate response is valid on
  // dut_out at this edge.
  logic             tap_vld;
  logic             tap_exp;
  logic [WIDTH-1:0] tap_vec;

  logic             accept;
  logic             mismatch;
  logic             last_cmp;
  logic [CNT_W-1:0] err_nxt;

  assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign mismatch = tap_vld && (dut_out != tap_exp);
  // Only the final vector can appear at the tap with value all-ones. While
  // counting in RUN, dut_in reaches LAST_VEC only at the RUN->DRAIN edge.
  assign last_cmp = (state_q == ST_DRAIN) && tap_vld && (tap_vec == LAST_VEC);

  // The count saturates at all-ones.
  assign err_nxt = (mismatch && !(&err_count)) ? err_count + CNT_W'(1) : err_count;

  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

  // ---------------------------------------------------------------------------
  // Expected-value pipeline. Vector v is driven in the cycle after edge Ev.
  // Its response is sampled DUT_LATENCY edges after it is first visible, so the
  // tap is either the live vector or a DUT_LATENCY-deep delayed copy.
  // ---------------------------------------------------------------------------
  generate
    if (DUT_LATENCY == 0) begin : g_no_delay
      assign tap_vld = drive_vld;
      assign tap_exp = |dut_in;
      assign tap_vec = dut_in;
    end else begin : g_delay
      logic [DUT_LATENCY-1:0] vld_q;
      logic [DUT_LATENCY-1:0] exp_q;
      logic [WIDTH-1:0]       vec_q [DUT_LATENCY];

      // NOTE: this small delay line is reset along with everything else, so a
      // reset mid-sweep cannot leave a stale valid record that would be
      // compared after the next start. A large RAM-style buffer would instead
      // clear its valid bits only.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
          exp_q <= '0;
          for (int i = 0; i < DUT_LATENCY; i++) vec_q[i] <= '0;
        end else begin
          vld_q[0] <= drive_vld;
          exp_q[0] <= |dut_in;
          vec_q[0] <= dut_in;
          for (int i = 1; i < DUT_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            exp_q[i] <= exp_q[i-1];
            vec_q[i] <= vec_q[i-1];
          end
        end
      end

      assign tap_vld = vld_q[DUT_LATENCY-1];
      assign tap_exp = exp_q[DUT_LATENCY-1];
      assign tap_vec = vec_q[DUT_LATENCY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments. All registers
  // therefore sample pre-edge values, and process order cannot change results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: state_d is assigned a default before the case statement. Without it,
  // a path that leaves it unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
      ST_RUN:           if (dut_in == LAST_VEC - WIDTH'(1)) state_d = ST_DRAIN;
      ST_DRAIN:         if (last_cmp) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Vector generator and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in         <= '0;
      drive_vld      <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      // The compare only fires in RUN/DRAIN, because the tap is never valid in
      // IDLE or DONE. An accepted start below therefore overrides it safely.
      if (mismatch) begin
        err_count <= err_nxt;
        if (!fail_valid) begin
          fail_valid     <= 1'b1;
          first_fail_vec <= tap_vec;
        end
      end

      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            dut_in         <= '0;
            drive_vld      <= 1'b1;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
          end
        end
        ST_RUN: begin
          dut_in <= dut_in + WIDTH'(1);
        end
        ST_DRAIN: begin
          drive_vld <= 1'b0;
          if (last_cmp) begin
            dut_in <= '0;
            pass   <= (err_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_or_gate_sweep_checker.sv
// -----------------------------------------------------------------------------
// Bench for or_gate_sweep_checker. Two instances share the clock and reset:
// u_dut0 uses DUT_LATENCY=0, and its gate behaviour is selected by gate_mode.
// u_dut2 uses DUT_LATENCY=2 and sees a correct OR gate registered twice.
// Expected sweep results come from a bench model. They are queued when a start
// is accepted and compared when done rises.
// -----------------------------------------------------------------------------
module tb_or_gate_sweep_checker;

  localparam int W  = 10;
  localparam int CW = 11;
  localparam int NV = 1 << W;

  typedef struct packed {
    logic        pass;
    logic [31:0] err;
    logic        fv;
    logic [31:0] ffv;
    logic [31:0] cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start0, start2;

  logic [W-1:0]  d0_in,  d2_in;
  logic          d0_out, d2_out;
  logic          d0_busy, d0_done, d0_pass, d0_fv;
  logic          d2_busy, d2_done, d2_pass, d2_fv;
  logic [CW-1:0] d0_err, d2_err;
  logic [W-1:0]  d0_ffv, d2_ffv;

  int gate_mode = 0;   // 0 correct, 1 stuck-at-0, 2 MSB ignored, 3 registered twice
  int sel = 0;         // which instance the sweep task observes
  int tests = 0;
  int fails = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  or_gate_sweep_checker #(.WIDTH(W), .DUT_LATENCY(0), .CNT_W(CW)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .dut_in(d0_in), .dut_out(d0_out),
    .busy(d0_busy), .done(d0_done), .pass(d0_pass), .err_count(d0_err),
    .fail_valid(d0_fv), .first_fail_vec(d0_ffv)
  );

  or_gate_sweep_checker #(.WIDTH(W), .DUT_LATENCY(2), .CNT_W(CW)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .dut_in(d2_in), .dut_out(d2_out),
    .busy(d2_busy), .done(d2_done), .pass(d2_pass), .err_count(d2_err),
    .fail_valid(d2_fv), .first_fail_vec(d2_ffv)
  );

  // Gate models
  logic g0_r1 = 1'b0, g0_r2 = 1'b0, g2_r1 = 1'b0, g2_r2 = 1'b0;
  always @(posedge clk) begin
    g0_r1 <= |d0_in;
    g0_r2 <= g0_r1;
    g2_r1 <= |d2_in;
    g2_r2 <= g2_r1;
  end

  always_comb begin
    case (gate_mode)
      0:       d0_out = |d0_in;
      1:       d0_out = 1'b0;
      2:       d0_out = |d0_in[W-2:0];
      default: d0_out = g0_r2;
    endcase
  end
  assign d2_out = g2_r2;

  // Observation mux for the sweep task
  logic          s_busy, s_done, s_pass, s_fv;
  logic [CW-1:0] s_err;
  logic [W-1:0]  s_in, s_ffv;
  always_comb begin
    if (sel == 2) begin
      s_busy = d2_busy; s_done = d2_done; s_pass = d2_pass; s_fv = d2_fv;
      s_err  = d2_err;  s_in   = d2_in;   s_ffv  = d2_ffv;
    end else begin
      s_busy = d0_busy; s_done = d0_done; s_pass = d0_pass; s_fv = d0_fv;
      s_err  = d0_err;  s_in   = d0_in;   s_ffv  = d0_ffv;
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Reference result of a full sweep for gate behaviour m at checker latency lat
  function automatic exp_t model(input int m, input int lat);
    exp_t e;
    e = '0;
    for (int v = 0; v < NV; v++) begin
      logic r, o;
      r = (v != 0);
      case (m)
        0:       o = r;
        1:       o = 1'b0;
        2:       o = ((v & (NV/2 - 1)) != 0);
        default: o = (v >= 2) ? ((v - 2) != 0) : 1'b0;  // two cycles stale
      endcase
      if (o != r) begin
        e.err = e.err + 1;
        if (!e.fv) begin
          e.fv  = 1'b1;
          e.ffv = 32'(v);
        end
      end
    end
    e.pass   = (e.err == 0);
    e.cycles = 32'(NV + lat);
    return e;
  endfunction

  // One sweep: raise start, check E0, follow dut_in, then compare results at done
  task automatic run_sweep(input int which, input int m, input bit hold);
    exp_t e, p;
    int   busy_cnt;
    int   cyc;
    bit   got_done;
    sel = which;
    e = model(m, (which == 2) ? 2 : 0);
    if (which == 2) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    sb_q.push_back(e);
    if (!hold) begin
      start0 = 1'b0;
      start2 = 1'b0;
    end
    check("e0_busy", 32'(s_busy), 32'd1);
    check("e0_done", 32'(s_done), 32'd0);
    check("e0_err",  32'(s_err),  32'd0);
    check("e0_fv",   32'(s_fv),   32'd0);
    check("e0_vec",  32'(s_in),   32'd0);
    busy_cnt = 1;
    cyc      = 0;
    got_done = 1'b0;
    for (int c = 1; c <= 3000 && !got_done; c++) begin
      @(posedge clk); #1;
      if (s_done) begin
        got_done = 1'b1;
        cyc      = c;
      end else begin
        busy_cnt += int'(s_busy);
        check("dut_in", 32'(s_in), 32'((c < NV - 1) ? c : NV - 1));
      end
    end
    if (!got_done) begin
      check("done_timeout", 32'd0, 32'd1);
      return;
    end
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
      return;
    end
    p = sb_q.pop_front();
    check("cycles",   32'(cyc),      p.cycles);
    check("busy_cnt", 32'(busy_cnt), p.cycles);
    check("pass",     32'(s_pass),   32'(p.pass));
    check("err",      32'(s_err),    p.err);
    check("fv",       32'(s_fv),     32'(p.fv));
    check("ffv",      32'(s_ffv),    p.ffv);
    check("end_busy", 32'(s_busy),   32'd0);
    check("end_vec",  32'(s_in),     32'd0);
  endtask

  initial begin
    bit hit;
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(d0_busy), 32'd0);
    check("rst_done", 32'(d0_done), 32'd0);
    check("rst_err",  32'(d0_err),  32'd0);
    check("rst_vec",  32'(d0_in),   32'd0);
    check("rst_pass", 32'(d2_pass), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // A start while in reset must not have been remembered.
    @(posedge clk); #1;
    check("idle_busy", 32'(d0_busy), 32'd0);

    gate_mode = 0; run_sweep(0, 0, 1'b0);   // correct gate
    gate_mode = 1; run_sweep(0, 1, 1'b0);   // stuck-at-0
    repeat (5) @(posedge clk);
    #1;
    check("hold_done", 32'(d0_done), 32'd1);
    check("hold_err",  32'(d0_err),  32'd1023);
    gate_mode = 2; run_sweep(0, 2, 1'b0);   // MSB ignored
    run_sweep(2, 0, 1'b0);                  // registered gate, matched latency
    gate_mode = 3; run_sweep(0, 3, 1'b0);   // registered gate, latency mismatch

    // Asynchronous reset in the middle of a sweep
    gate_mode = 0;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 400 && !hit; c++) begin
      if (d0_in == W'(300)) hit = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("reach_300", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_vec",  32'(d0_in),   32'd0);
    check("arst_busy", 32'(d0_busy), 32'd0);
    check("arst_done", 32'(d0_done), 32'd0);
    check("arst_pass", 32'(d0_pass), 32'd0);
    check("arst_err",  32'(d0_err),  32'd0);
    check("arst_fv",   32'(d0_fv),   32'd0);
    check("arst_ffv",  32'(d0_ffv),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, 0, 1'b0);

    // start held high: ignored while busy, re-accepted from DONE
    run_sweep(0, 0, 1'b1);
    run_sweep(0, 0, 1'b0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
